// File: rtl/a2d_resp.sv
// rtl/a2d_resp.sv - SPI responder modelling the pipelined A2D converter channel
// Define A2D_RESP_ERR_EN to add the saturating abort counter output abrt_cnt.
module a2d_resp (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic [95:0] ch_data,
   output logic        MISO,
   output logic        frm_done,
   output logic [2:0]  cur_chnl
`ifdef A2D_RESP_ERR_EN
   ,
   output logic [7:0]  abrt_cnt
`endif
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  ss_sync;
   logic [2:0]  sclk_sync;
   logic [2:0]  mosi_sync;
   logic        ss_fall;
   logic        ss_rise;
   logic        sclk_rise;
   logic        sclk_fall;
   logic        mosi_bit;
   logic        start_frm;
   logic        end_ok;
   logic        end_abort;
   logic [4:0]  bit_cnt;
   logic [15:0] cmd_shft;
   logic [15:0] resp_shft;
   logic [11:0] snap;

   // Synchronizers are deliberately left out of reset so that a reset taken
   // while SS_n is held low cannot fabricate a falling edge afterwards.
   always_ff @(posedge clk) begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[1:0], MOSI};
   end

   assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
   assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
   assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
   assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
   assign mosi_bit  =  mosi_sync[2];

   assign snap = ch_data[{4'd0, cur_chnl} * 7'd12 +: 12];

   // A fall whose matching rise is already in the first stage is a glitch.
   always_comb begin
      state_nxt = state;
      start_frm = 1'b0;
      end_ok    = 1'b0;
      end_abort = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall && !ss_sync[0]) begin
               start_frm = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_nxt = IDLE;
               if (bit_cnt == 5'd16) begin
                  end_ok = 1'b1;
               end else begin
                  end_abort = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         frm_done  <= 1'b0;
         cur_chnl  <= 3'b000;
         bit_cnt   <= 5'd0;
         cmd_shft  <= 16'h0000;
         resp_shft <= 16'h0000;
      end else begin
         state    <= state_nxt;
         frm_done <= end_ok;
         if (start_frm) begin
            resp_shft <= {4'b0000, snap};
            cmd_shft  <= 16'h0000;
            bit_cnt   <= 5'd0;
         end else if (end_ok || end_abort) begin
            cmd_shft <= 16'h0000;
         end else if (state == SHIFT) begin
            if (sclk_rise) begin
               cmd_shft <= {cmd_shft[14:0], mosi_bit};
               // Saturate at 17 so an over-clocked frame still reads as an abort.
               if (bit_cnt != 5'd17) begin
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            if (sclk_fall) begin
               resp_shft <= {resp_shft[14:0], 1'b0};
            end
         end
         if (end_ok) begin
            cur_chnl <= cmd_shft[13:11];
         end
      end
   end

`ifdef A2D_RESP_ERR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         abrt_cnt <= 8'h00;
      end else if (end_abort && (abrt_cnt != 8'hFF)) begin
         abrt_cnt <= abrt_cnt + 8'h01;
      end
   end
`endif

   assign MISO = (state == SHIFT) ? resp_shft[15] : 1'b0;

endmodule

// File: tb/tb_a2d_resp.sv
// tb/tb_a2d_resp.sv - randomized self-checking bench for a2d_resp against a frame-level model
module tb_a2d_resp;

   logic        clk;
   logic        rst_n;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic [95:0] ch_data;
   logic        MISO;
   logic        frm_done;
   logic [2:0]  cur_chnl;
`ifdef A2D_RESP_ERR_EN
   logic [7:0]  abrt_cnt;
`endif

   a2d_resp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .ch_data  (ch_data),
      .MISO     (MISO),
      .frm_done (frm_done),
      .cur_chnl (cur_chnl)
`ifdef A2D_RESP_ERR_EN
      ,
      .abrt_cnt (abrt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int done_pulses = 0;

   // Reference model state: channel values as the master sees them, and the
   // channel that the next frame will report.
   logic [11:0] m_ch [8];
   logic [2:0]  m_cur;
   int          m_abrt;

   always @(negedge clk) if (frm_done === 1'b1) done_pulses++;

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [95:0] pack_ch();
      logic [95:0] v;
      for (int k = 0; k < 8; k++) v[k*12 +: 12] = m_ch[k];
      return v;
   endfunction

   task automatic run_frame(input logic [15:0] cmd, input int nbits, input int chg_at,
                            input logic [95:0] chg_val, output logic [15:0] got, output int ndone);
      int d0;
      d0   = done_pulses;
      got  = 16'h0000;
      MOSI = cmd[15];
      SS_n = 1'b0;
      wait_clk(10);
      for (int i = 0; i < nbits; i++) begin
         if (i < 16) got[15-i] = MISO;
         if (i == chg_at) ch_data = chg_val;
         SCLK = 1'b1;
         wait_clk(10);
         SCLK = 1'b0;
         MOSI = (i < 15) ? cmd[14-i] : 1'b0;
         wait_clk(10);
      end
      SS_n = 1'b1;
      wait_clk(10);
      ndone = done_pulses - d0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      for (int k = 0; k < 8; k++) m_ch[k] = 12'h000;
      ch_data = pack_ch();
      m_cur = 3'd0; m_abrt = 0;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(3);
      vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL reset_miso got %b exp 0", MISO); end
      vecs++; if (frm_done !== 1'b0) begin errs++; $display("FAIL reset_frm_done got %b exp 0", frm_done); end
      vecs++; if (cur_chnl !== 3'd0) begin errs++; $display("FAIL reset_cur_chnl got %0d exp 0", cur_chnl); end
`ifdef A2D_RESP_ERR_EN
      vecs++; if (abrt_cnt !== 8'd0) begin errs++; $display("FAIL reset_abrt_cnt got %0d exp 0", abrt_cnt); end
`endif
   endtask

   task automatic test_spec_frames();
      logic [15:0] got; int nd;
      m_ch[0] = 12'hABC; ch_data = pack_ch();
      run_frame(16'h2000, 16, -1, ch_data, got, nd);
      vecs++; if (got !== 16'h0ABC) begin errs++; $display("FAIL f1_miso got %h exp 0abc", got); end
      vecs++; if (nd !== 1) begin errs++; $display("FAIL f1_done got %0d exp 1", nd); end
      vecs++; if (cur_chnl !== 3'd4) begin errs++; $display("FAIL f1_cur got %0d exp 4", cur_chnl); end
      vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL f1_idle_miso got %b exp 0", MISO); end
      m_ch[4] = 12'h123; ch_data = pack_ch();
      run_frame(16'h2800, 16, -1, ch_data, got, nd);
      vecs++; if (got !== 16'h0123) begin errs++; $display("FAIL f2_miso got %h exp 0123", got); end
      vecs++; if (cur_chnl !== 3'd5) begin errs++; $display("FAIL f2_cur got %0d exp 5", cur_chnl); end
      m_cur = 3'd5;
   endtask

   task automatic test_round_robin();
      logic [15:0] got; logic [15:0] cmd; logic [15:0] exp; int nd;
      logic [2:0] chs [4];
      chs[0] = 3'd0; chs[1] = 3'd4; chs[2] = 3'd5; chs[3] = 3'd6;
      for (int k = 0; k < 8; k++) m_ch[k] = 12'(k * 12'h111 + 12'h00F);
      ch_data = pack_ch();
      for (int c = 0; c < 4; c++) begin
         for (int f = 0; f < 2; f++) begin
            cmd = 16'($urandom);
            cmd[13:11] = chs[c];
            exp = {4'h0, m_ch[m_cur]};
            run_frame(cmd, 16, -1, ch_data, got, nd);
            m_cur = chs[c];
            vecs++; if (got !== exp) begin errs++; $display("FAIL rr_miso ch%0d f%0d got %h exp %h", chs[c], f, got, exp); end
            vecs++; if (nd !== 1) begin errs++; $display("FAIL rr_done got %0d exp 1", nd); end
            vecs++; if (cur_chnl !== m_cur) begin errs++; $display("FAIL rr_cur got %0d exp %0d", cur_chnl, m_cur); end
         end
      end
   endtask

   task automatic test_abort();
      logic [15:0] got; logic [15:0] exp; int nd;
      exp = {4'h0, m_ch[m_cur]};
      run_frame(16'h3000, 9, -1, ch_data, got, nd);
      m_abrt++;
      vecs++; if (got[15:7] !== exp[15:7]) begin errs++; $display("FAIL abort9_miso got %h exp %h", got[15:7], exp[15:7]); end
      vecs++; if (nd !== 0) begin errs++; $display("FAIL abort9_done got %0d exp 0", nd); end
      vecs++; if (cur_chnl !== m_cur) begin errs++; $display("FAIL abort9_cur got %0d exp %0d", cur_chnl, m_cur); end
      run_frame(16'h3800, 17, -1, ch_data, got, nd);
      m_abrt++;
      vecs++; if (nd !== 0) begin errs++; $display("FAIL abort17_done got %0d exp 0", nd); end
      vecs++; if (cur_chnl !== m_cur) begin errs++; $display("FAIL abort17_cur got %0d exp %0d", cur_chnl, m_cur); end
`ifdef A2D_RESP_ERR_EN
      vecs++; if (abrt_cnt !== 8'(m_abrt)) begin errs++; $display("FAIL abrt_cnt got %0d exp %0d", abrt_cnt, m_abrt); end
`endif
   endtask

   task automatic test_random();
      logic [15:0] got; logic [15:0] cmd; logic [15:0] exp; int nd;
      for (int n = 0; n < 12; n++) begin
         for (int k = 0; k < 8; k++) m_ch[k] = 12'($urandom);
         ch_data = pack_ch();
         cmd = 16'($urandom);
         exp = {4'h0, m_ch[m_cur]};
         run_frame(cmd, 16, -1, ch_data, got, nd);
         m_cur = cmd[13:11];
         vecs++; if (got !== exp) begin errs++; $display("FAIL rand_miso n%0d got %h exp %h", n, got, exp); end
         vecs++; if (cur_chnl !== m_cur) begin errs++; $display("FAIL rand_cur n%0d got %0d exp %0d", n, cur_chnl, m_cur); end
      end
   endtask

   task automatic test_midframe_data();
      logic [15:0] got; logic [15:0] exp; logic [11:0] newv; int nd;
      exp  = {4'h0, m_ch[m_cur]};
      newv = ~m_ch[m_cur];
      m_ch[m_cur] = newv;
      run_frame({2'b00, m_cur, 11'h000}, 16, 3, pack_ch(), got, nd);
      vecs++; if (got !== exp) begin errs++; $display("FAIL snap_miso got %h exp %h", got, exp); end
      run_frame({2'b00, m_cur, 11'h000}, 16, -1, ch_data, got, nd);
      vecs++; if (got !== {4'h0, newv}) begin errs++; $display("FAIL snap_next got %h exp %h", got, {4'h0, newv}); end
   endtask

   task automatic test_glitch();
      int d0; logic [2:0] c0;
      d0 = done_pulses; c0 = cur_chnl;
      SS_n = 1'b0; wait_clk(1); SS_n = 1'b1;
      wait_clk(2);
      vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL glitch_miso got %b exp 0", MISO); end
      wait_clk(8);
      vecs++; if (done_pulses !== d0) begin errs++; $display("FAIL glitch_done got %0d exp %0d", done_pulses, d0); end
      vecs++; if (cur_chnl !== m_cur) begin errs++; $display("FAIL glitch_cur got %0d exp %0d", cur_chnl, m_cur); end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] got; int nd; int d0;
      m_ch[0] = 12'h5A5; ch_data = pack_ch();
      d0 = done_pulses;
      MOSI = 1'b1; SS_n = 1'b0;
      wait_clk(10);
      for (int i = 0; i < 5; i++) begin
         SCLK = 1'b1; wait_clk(10); SCLK = 1'b0; wait_clk(10);
      end
      rst_n = 1'b0; wait_clk(1); rst_n = 1'b1;
      m_cur = 3'd0; m_abrt = 0;
      wait_clk(2);
      vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL rstmid_miso got %b exp 0", MISO); end
      vecs++; if (cur_chnl !== 3'd0) begin errs++; $display("FAIL rstmid_cur got %0d exp 0", cur_chnl); end
      for (int i = 0; i < 3; i++) begin
         SCLK = 1'b1; wait_clk(10); SCLK = 1'b0; wait_clk(10);
      end
      vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL rstmid_hold_miso got %b exp 0", MISO); end
      SS_n = 1'b1; wait_clk(10);
      vecs++; if (done_pulses !== d0) begin errs++; $display("FAIL rstmid_done got %0d exp %0d", done_pulses, d0); end
      run_frame(16'h1000, 16, -1, ch_data, got, nd);
      vecs++; if (got !== 16'h05A5) begin errs++; $display("FAIL rstmid_next_miso got %h exp 05a5", got); end
      vecs++; if (cur_chnl !== 3'd2) begin errs++; $display("FAIL rstmid_next_cur got %0d exp 2", cur_chnl); end
   endtask

   initial begin
      test_reset();
      test_spec_frames();
      test_round_robin();
      test_abort();
      test_random();
      test_midframe_data();
      test_glitch();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
